// File: rtl/demux_1to8_capture_pkg.sv
// ============================================================================
// Module  : demux_1to8_capture_pkg
// Brief   : Shared state encoding and default sizing for the 1-to-8 demux capture.
// Revision: 1.0
// ============================================================================
`default_nettype none

package demux_1to8_capture_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;

   localparam int NUM_CH_DEF = 8;
   localparam int SEL_W_DEF  = 3;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_SHIFT  = ST_SHIFT,
      S_PARITY = ST_PARITY
   } state_e;

endpackage

`default_nettype wire

// File: rtl/demux_1to8_capture_if.sv
// ============================================================================
// Module  : demux_1to8_capture_if
// Brief   : Serial-in / parallel-out bundle between a bit source and the demux.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface demux_1to8_capture_if
   import demux_1to8_capture_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int SEL_W  = SEL_W_DEF
);
   logic              start;
   logic              din;
   logic              din_valid;
   logic              busy;
   logic [SEL_W-1:0]  sel_cur;
   logic [NUM_CH-1:0] dout;
   logic              out_valid;
   logic              parity_err;

   modport master (
      output start, din, din_valid,
      input  busy, sel_cur, dout, out_valid, parity_err
   );

   modport slave (
      input  start, din, din_valid,
      output busy, sel_cur, dout, out_valid, parity_err
   );
endinterface

`default_nettype wire

// File: rtl/demux_1to8_capture_slot_counter.sv
// ============================================================================
// Module  : demux_slot_counter
// Brief   : Slot index counter with clear, enable and terminal-slot flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux_slot_counter
   import demux_1to8_capture_pkg::*;
#(
   parameter int SEL_W = SEL_W_DEF,
   parameter int LAST  = NUM_CH_DEF - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [SEL_W-1:0] cnt,
   output logic             term
);
   localparam logic [SEL_W-1:0] c_last = SEL_W'(LAST);

   logic [SEL_W-1:0] cnt_q, cnt_d;

   // Explicit wrap at the terminal slot keeps non-power-of-two frames correct
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == c_last) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign term = (cnt_q == c_last);
endmodule

`default_nettype wire

// File: rtl/demux_1to8_capture.sv
// ============================================================================
// Module  : demux_1to8_capture
// Brief   : Frame-based serial-to-parallel demux; optional even-parity trailer
//           bit enabled by macro DEMUX_PARITY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux_1to8_capture
   import demux_1to8_capture_pkg::*;
#(
   parameter int NUM_CH    = NUM_CH_DEF,
   parameter int SEL_W     = SEL_W_DEF,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   demux_1to8_capture_if.slave  bus
);
   localparam logic [SEL_W-1:0] c_last_slot = SEL_W'(NUM_CH - 1);

   state_e            state_q, state_d;
   logic [NUM_CH-1:0] buf_q, buf_d;
   logic [NUM_CH-1:0] dout_q, dout_d;
   logic              out_valid_q, out_valid_d;
   logic [SEL_W-1:0]  sel_cur;
   logic [SEL_W-1:0]  slot_idx;
   logic              cnt_term;
   logic              wr_en;

   // start wins over a coincident valid bit, so it also gates the write strobe
   assign wr_en = (state_q == S_SHIFT) && bus.din_valid && !bus.start;

   demux_slot_counter #(
      .SEL_W (SEL_W),
      .LAST  (NUM_CH - 1)
   ) u_slot_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (bus.start),
      .en   (wr_en),
      .cnt  (sel_cur),
      .term (cnt_term)
   );

   assign slot_idx = MSB_FIRST ? (c_last_slot - sel_cur) : sel_cur;

   generate
      for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
         assign buf_d[k] = bus.start                          ? 1'b0    :
                           (wr_en && (slot_idx == SEL_W'(k))) ? bus.din :
                                                                buf_q[k];
      end
   endgenerate

`ifdef DEMUX_PARITY_EN
   logic parity_err_q, parity_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      dout_d      = dout_q;
      out_valid_d = 1'b0;
`ifdef DEMUX_PARITY_EN
      parity_err_d = parity_err_q;
`endif
      if (bus.start) begin
         state_d = S_SHIFT;
      end else begin
         case (state_q)
            S_SHIFT: begin
               if (wr_en && cnt_term) begin
`ifdef DEMUX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d     = S_IDLE;
                  dout_d      = buf_d;
                  out_valid_d = 1'b1;
`endif
               end
            end
`ifdef DEMUX_PARITY_EN
            S_PARITY: begin
               if (bus.din_valid) begin
                  state_d      = S_IDLE;
                  dout_d       = buf_q;
                  out_valid_d  = 1'b1;
                  parity_err_d = ^{buf_q, bus.din};
               end
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         buf_q       <= '0;
         dout_q      <= '0;
         out_valid_q <= 1'b0;
`ifdef DEMUX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
`ifdef DEMUX_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.sel_cur   = sel_cur;
   assign bus.dout      = dout_q;
   assign bus.out_valid = out_valid_q;
`ifdef DEMUX_PARITY_EN
   assign bus.parity_err = parity_err_q;
`else
   assign bus.parity_err = 1'b0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_demux_1to8_capture.sv
// ============================================================================
// Module  : tb_demux_1to8_capture
// Brief   : Randomised and directed bench for demux_1to8_capture against a
//           frame-level reference model (honours DEMUX_PARITY_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_demux_1to8_capture;
   localparam int NUM_CH    = 8;
   localparam int SEL_W     = 3;
   localparam bit MSB_FIRST = 1'b0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   demux_1to8_capture_if #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();

   demux_1to8_capture #(
      .NUM_CH    (NUM_CH),
      .SEL_W     (SEL_W),
      .MSB_FIRST (MSB_FIRST)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;
   int ov_seen  = 0;

   // Frame-level model: collected bits of the frame in flight plus last result
   bit         m_active;
   bit         m_ppar;
   bit         m_bits[$];
   logic [7:0] m_word;
   logic [7:0] m_dout;
   bit         m_ov;
   bit         m_perr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] word_of(input bit q[$]);
      logic [7:0] w = 8'h00;
      foreach (q[i]) w[MSB_FIRST ? (NUM_CH - 1 - i) : i] = q[i];
      return w;
   endfunction

   task automatic model_reset();
      m_active = 0; m_ppar = 0; m_bits.delete();
      m_word = 8'h00; m_dout = 8'h00; m_ov = 0; m_perr = 0;
   endtask

   task automatic model_step(input bit s, input bit d, input bit v);
      m_ov = 0;
      if (s) begin
         m_active = 1; m_ppar = 0; m_bits.delete();
      end else if (m_active && v) begin
         if (m_ppar) begin
            m_dout   = m_word;
            m_perr   = (($countones(m_word) + int'(d)) % 2) != 0;
            m_ov     = 1;
            m_active = 0;
            m_ppar   = 0;
         end else begin
            m_bits.push_back(d);
            if (m_bits.size() == NUM_CH) begin
               m_word = word_of(m_bits);
               m_bits.delete();
`ifdef DEMUX_PARITY_EN
               m_ppar = 1;
`else
               m_dout   = m_word;
               m_ov     = 1;
               m_active = 0;
`endif
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",       32'(bus.busy),       32'(m_active));
         check("sel_cur",    32'(bus.sel_cur),    (m_active && !m_ppar) ? 32'(m_bits.size()) : 32'd0);
         check("dout",       32'(bus.dout),       32'(m_dout));
         check("out_valid",  32'(bus.out_valid),  32'(m_ov));
         check("parity_err", 32'(bus.parity_err), 32'(m_perr));
         if (bus.out_valid) ov_seen++;
      end
   end

   task automatic cycle(input bit s, input bit d, input bit v);
      bus.start = s; bus.din = d; bus.din_valid = v;
      @(posedge clk);
      model_step(s, d, v);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom), 1'($urandom));
   endtask

   // Trailer bit only exists in the parity build; p is the bit to send there
   task automatic finish_frame(input bit p);
`ifdef DEMUX_PARITY_EN
      cycle(1'b0, p, 1'b1);
`else
      if (p) begin end
`endif
   endtask

   task automatic send_bits(input logic [7:0] w, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && i > 0) cycle(1'b0, 1'($urandom), 1'b0);
         cycle(1'b0, w[i], 1'b1);
      end
   endtask

   task automatic send_frame(input logic [7:0] w, input bit gaps);
      cycle(1'b1, 1'($urandom), 1'($urandom));
      send_bits(w, NUM_CH, gaps);
      finish_frame(^w);
   endtask

   int ov0;

   initial begin
      rst = 1'b1;
      bus.start = 0; bus.din = 0; bus.din_valid = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      check("rst_dout",  32'(bus.dout),      32'h0);
      check("rst_busy",  32'(bus.busy),      32'h0);
      check("rst_sel",   32'(bus.sel_cur),   32'h0);
      check("rst_ov",    32'(bus.out_valid), 32'h0);

      idle(3);
      send_frame(8'hE5, 1'b0);
      check("f1_ov",   32'(bus.out_valid), 32'h1);
      check("f1_dout", 32'(bus.dout),      32'hE5);
      idle(1);
      check("f1_ov_off", 32'(bus.out_valid), 32'h0);
      check("f1_busy",   32'(bus.busy),      32'h0);

      idle(2);
      cycle(1'b1, 1'b0, 1'b0);
      send_bits(8'hE5, 3, 1'b1);
      cycle(1'b0, 1'b1, 1'b0);
      check("gap_sel_hold", 32'(bus.sel_cur), 32'd3);
      for (int i = 3; i < NUM_CH; i++) begin
         cycle(1'b0, 1'($urandom), 1'b0);
         cycle(1'b0, 1'((8'hE5 >> i) & 8'h01), 1'b1);
      end
      finish_frame(1'b1);
      check("gap_dout", 32'(bus.dout), 32'hE5);

      idle(2);
      ov0 = ov_seen;
      cycle(1'b1, 1'b0, 1'b0);
      send_bits(8'hFF, 4, 1'b0);
      send_frame(8'h3C, 1'b0);
      idle(1);
      check("abort_pulses", 32'(ov_seen - ov0), 32'd1);
      check("abort_dout",   32'(bus.dout),      32'h3C);

      cycle(1'b1, 1'b0, 1'b0);
      send_bits(8'hA5, 5, 1'b0);
      rst = 1'b1;
      model_reset();
      #1;
      check("arst_dout", 32'(bus.dout),    32'h0);
      check("arst_sel",  32'(bus.sel_cur), 32'h0);
      check("arst_busy", 32'(bus.busy),    32'h0);
      idle(2);
      rst = 1'b0;

      idle(2);
      ov0 = ov_seen;
      send_frame(8'hE5, 1'b0);
      check("b2b_ov1", 32'(bus.out_valid), 32'h1);
      send_frame(8'h1A, 1'b0);
      idle(1);
      check("b2b_pulses", 32'(ov_seen - ov0), 32'd2);
      check("b2b_dout",   32'(bus.dout),      32'h1A);

`ifdef DEMUX_PARITY_EN
      idle(1);
      cycle(1'b1, 1'b0, 1'b0);
      send_bits(8'hE5, NUM_CH, 1'b0);
      cycle(1'b0, 1'b1, 1'b1);
      check("par_ok_err",  32'(bus.parity_err), 32'h0);
      check("par_ok_dout", 32'(bus.dout),       32'hE5);
      idle(1);
      cycle(1'b1, 1'b0, 1'b0);
      send_bits(8'hE5, NUM_CH, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      check("par_bad_err",  32'(bus.parity_err), 32'h1);
      check("par_bad_dout", 32'(bus.dout),       32'hE5);
      idle(2);
      check("par_err_hold", 32'(bus.parity_err), 32'h1);
`endif

      for (int i = 0; i < 600; i++) begin
         cycle(($urandom % 16) == 0, 1'($urandom), ($urandom % 10) < 7);
      end
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

`default_nettype wire
